pc_fetch: RTL and testbench

Program-counter register and instruction-fetch sequencer for the multi-cycle MIPS core. It holds the architectural PC and feeds it to the next-PC selector. It commits the selector's result on the controller's write strobe. It runs a request/acknowledge fetch to instruction memory and latches the returned word into the instruction register. Bus errors and fetch timeouts are reported to CP0 with the faulting PC.

---
 rtl/pc_fetch.sv | 109 ++++++++++
 tb/tb_pc_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register and request/acknowledge instruction-fetch sequencer
module pc_fetch #(
    parameter logic [29:0] RESET_PC       = 30'h0000_0C00,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_I,
    input  logic        rstn_I,
    input  logic [29:0] npc_I,
    input  logic        PCWr_I,
    input  logic        fetch_start_I,
    input  logic        flush_I,
    output logic        imem_req_O,
    output logic [29:0] imem_addr_O,
    input  logic        imem_ack_I,
    input  logic        imem_err_I,
    input  logic [31:0] imem_data_I,
    output logic [29:0] pc_O,
    output logic [31:0] ir_O,
    output logic        fetch_busy_O,
    output logic        fetch_done_O,
    output logic        ibe_O,
    output logic [29:0] badpc_O
);

    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t        state_q;
    logic [29:0]   pc_q, pc_d;
    logic [29:0]   fa_q;
    logic [29:0]   badpc_q;
    logic [31:0]   ir_q;
    logic [TW-1:0] tmo_q;
    logic          req_q, done_q, ibe_q;

    // PC commit is independent of the fetch FSM; the fetch captures the pre-edge PC.
    always_comb begin
        pc_d = pc_q;
        if (PCWr_I) pc_d = npc_I;
    end

    always_ff @(posedge clk_I or negedge rstn_I) begin
        if (!rstn_I) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fa_q    <= RESET_PC;
            badpc_q <= '0;
            ir_q    <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            ibe_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            done_q <= 1'b0;
            ibe_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch_start_I) begin
                        fa_q    <= pc_q;
                        tmo_q   <= '0;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (flush_I) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (imem_err_I) begin
                        badpc_q <= fa_q;
                        ibe_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ERR;
                    end else if (imem_ack_I) begin
                        ir_q    <= imem_data_I;
                        done_q  <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                        badpc_q <= fa_q;
                        ibe_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ERR;
                    end else if (tmo_q != TMO_MAX) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req_O   = req_q;
    assign fetch_busy_O = req_q;
    assign imem_addr_O  = fa_q;
    assign pc_O         = pc_q;
    assign ir_O         = ir_q;
    assign fetch_done_O = done_q;
    assign ibe_O        = ibe_q;
    assign badpc_O      = badpc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [29:0] npc = '0;
    logic        pcwr = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        req;
    logic [29:0] addr;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [31:0] data = '0;
    logic [29:0] pc;
    logic [31:0] ir;
    logic        busy;
    logic        done;
    logic        ibe;
    logic [29:0] badpc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(30'h0000_0C00), .TIMEOUT_CYCLES(16)) dut (
        .clk_I(clk), .rstn_I(rstn), .npc_I(npc), .PCWr_I(pcwr),
        .fetch_start_I(start), .flush_I(flush),
        .imem_req_O(req), .imem_addr_O(addr),
        .imem_ack_I(ack), .imem_err_I(err), .imem_data_I(data),
        .pc_O(pc), .ir_O(ir), .fetch_busy_O(busy), .fetch_done_O(done),
        .ibe_O(ibe), .badpc_O(badpc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge: the start of the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_pc", 32'(pc), 32'h0000_0C00);
        check("rst_ir", ir, 32'h0);
        check("rst_addr", 32'(addr), 32'h0000_0C00);
        check("rst_badpc", 32'(badpc), 32'h0);
        check("rst_req", 32'(req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ibe", 32'(ibe), 32'h0);
        rstn = 1'b1;
        step();

        // Basic fetch with parallel PC write
        start = 1'b1; pcwr = 1'b1; npc = 30'h0000_0C01;
        step();
        start = 1'b0; pcwr = 1'b0;
        check("basic_req", 32'(req), 32'h1);
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_addr", 32'(addr), 32'h0000_0C00);
        check("basic_pc", 32'(pc), 32'h0000_0C01);
        ack = 1'b1; data = 32'h2408_0005;
        step();
        ack = 1'b0;
        check("basic_done", 32'(done), 32'h1);
        check("basic_ir", ir, 32'h2408_0005);
        check("basic_req_low", 32'(req), 32'h0);
        start = 1'b1;                        // ignored while in DONE
        step();
        start = 1'b0;
        check("basic_done_pulse", 32'(done), 32'h0);
        check("done_start_ignored", 32'(req), 32'h0);

        // Wait states with a PC write during REQ
        pcwr = 1'b1; npc = 30'h0000_0C00;
        step();
        pcwr = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("wait_req_c%0d", c), 32'(req), 32'h1);
            check($sformatf("wait_addr_c%0d", c), 32'(addr), 32'h0000_0C00);
            check($sformatf("wait_nodone_c%0d", c), 32'(done), 32'h0);
            if (c == 3) begin pcwr = 1'b1; npc = 30'h0000_1234; end
            if (c == 6) begin ack = 1'b1; data = 32'h8C09_0004; end
            step();
            pcwr = 1'b0;
            if (c == 3) check("wait_pc", 32'(pc), 32'h0000_1234);
        end
        ack = 1'b0;
        check("wait_done", 32'(done), 32'h1);
        check("wait_ir", ir, 32'h8C09_0004);
        step();

        // Error wins over a simultaneous ack
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_req", 32'(req), 32'h1);
        check("err_addr", 32'(addr), 32'h0000_1234);
        err = 1'b1; ack = 1'b1; data = 32'hFFFF_FFFF;
        step();
        err = 1'b0; ack = 1'b0;
        check("err_ibe", 32'(ibe), 32'h1);
        check("err_nodone", 32'(done), 32'h0);
        check("err_badpc", 32'(badpc), 32'h0000_1234);
        check("err_ir_kept", ir, 32'h8C09_0004);
        step();
        check("err_ibe_pulse", 32'(ibe), 32'h0);

        // Timeout with no response
        pcwr = 1'b1; npc = 30'h0000_0ABC;
        step();
        pcwr = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("tmo_req_c%0d", c), 32'(req), 32'h1);
            check($sformatf("tmo_noibe_c%0d", c), 32'(ibe), 32'h0);
            step();
        end
        check("tmo_ibe", 32'(ibe), 32'h1);
        check("tmo_req_low", 32'(req), 32'h0);
        check("tmo_badpc", 32'(badpc), 32'h0000_0ABC);
        check("tmo_ir_kept", ir, 32'h8C09_0004);
        step();

        // Flush followed by a stale ack, then a clean fetch
        start = 1'b1;
        step();
        start = 1'b0;
        check("fl_req", 32'(req), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_req_low", 32'(req), 32'h0);
        check("fl_nodone", 32'(done), 32'h0);
        ack = 1'b1; data = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        check("fl_stale_nodone", 32'(done), 32'h0);
        check("fl_stale_ir", ir, 32'h8C09_0004);
        check("fl_stale_req", 32'(req), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("fl2_req", 32'(req), 32'h1);
        check("fl2_addr", 32'(addr), 32'h0000_0ABC);
        ack = 1'b1; data = 32'h0000_1234;
        step();
        ack = 1'b0;
        check("fl2_done", 32'(done), 32'h1);
        check("fl2_ir", ir, 32'h0000_1234);
        step();

        // Asynchronous reset in the middle of REQ
        start = 1'b1;
        step();
        start = 1'b0;
        check("ar_req_before", 32'(req), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_req", 32'(req), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_pc", 32'(pc), 32'h0000_0C00);
        check("ar_ir", ir, 32'h0);
        check("ar_addr", 32'(addr), 32'h0000_0C00);
        check("ar_badpc", 32'(badpc), 32'h0);
        check("ar_done", 32'(done), 32'h0);
        check("ar_ibe", 32'(ibe), 32'h0);
        step();
        rstn = 1'b1;
        step();
        check("ar_idle_req", 32'(req), 32'h0);
        check("ar_idle_done", 32'(done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
